// File: rtl/z80_bus_pkg.sv
// z80_bus_pkg: shared Z80 I/O bus FSM states, VDP port map and address helper
package z80_bus_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_T1, ST_T2, ST_TW, ST_T3, ST_RECOVER} state_t;
   localparam logic [7:0] VDP_PORT_BASE = 8'h98;
   localparam logic [1:0] PORT_DATA   = 2'd0;
   localparam logic [1:0] PORT_CTRL   = 2'd1;
   localparam logic [1:0] PORT_PAL    = 2'd2;
   localparam logic [1:0] PORT_REGIND = 2'd3;
   function automatic logic [7:0] port_addr(input logic [7:0] base, input logic [1:0] p);
      return base | {6'b0, p};
   endfunction
endpackage

// File: rtl/z80_tstate_timer.sv
// z80_tstate_timer: per-state tick counter; clk/reset_n, clear holds it at 0,
// last = final count value, cnt = current tick, last_tick = cnt reached last
module z80_tstate_timer #(
   parameter int CW = 3
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          clear,
   input  logic [CW-1:0] last,
   output logic [CW-1:0] cnt,
   output logic          last_tick
);
   assign last_tick = cnt == last;
   // Every timed state ends on last_tick, so wrapping here reloads the next state
   always_ff @(posedge clk)
      if (!reset_n || clear || last_tick) cnt <= '0;
      else cnt <= cnt + CW'(1);
endmodule

// File: rtl/z80_io_initiator.sv
// z80_io_initiator: Z80-style I/O cycle master towards VDP ports base..base+3.
// Request side: req/wr/port/wdata in, ready/done/err/rdata out.
// Bus side: addr, iorq_n, rd_n, wr_n, cd_out/cd_oe, cd_in, wait_n (async).
module z80_io_initiator
   import z80_bus_pkg::*;
#(
   parameter int         T_STATE_CLKS = 8,
   parameter int         WAIT_STATES  = 1,
   parameter int         GAP_CLKS     = 4,
   parameter int         WAIT_TIMEOUT = 255,
   parameter logic [7:0] PORT_BASE    = VDP_PORT_BASE
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       req,
   input  logic       wr,
   input  logic [1:0] port,
   input  logic [7:0] wdata,
   output logic       ready,
   output logic       done,
   output logic       err,
   output logic [7:0] rdata,
   output logic [7:0] addr,
   output logic       iorq_n,
   output logic       rd_n,
   output logic       wr_n,
   output logic [7:0] cd_out,
   output logic       cd_oe,
   input  logic [7:0] cd_in,
   input  logic       wait_n
);
   localparam int TMAX = T_STATE_CLKS > GAP_CLKS ? T_STATE_CLKS : GAP_CLKS;
   localparam int CW = $clog2(TMAX);
   localparam logic [CW-1:0] T_LAST = CW'(T_STATE_CLKS - 1);
   localparam logic [CW-1:0] G_LAST = CW'(GAP_CLKS - 1);
   localparam int EW = WAIT_TIMEOUT > 0 ? $clog2(WAIT_TIMEOUT + 1) : 1;
   localparam logic [EW-1:0] EXT_MAX = EW'(WAIT_TIMEOUT);
   localparam logic [1:0] TW_LAST = WAIT_STATES > 0 ? 2'(WAIT_STATES - 1) : 2'd0;
   localparam bit NO_WS = WAIT_STATES == 0;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic            last_tick;
   logic            wr_l, err_l, wait_q1, wait_s;
   logic [1:0]      tw_n;
   logic [EW-1:0]   ext;
   logic            sample_pt, timeout, strobe, rec_first, accept;

   z80_tstate_timer #(.CW(CW)) u_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (state == ST_IDLE),
      .last      (state == ST_RECOVER ? G_LAST : T_LAST),
      .cnt       (cnt),
      .last_tick (last_tick)
   );

   // wait_n only matters on the last clock of the final TW (or of T2 when there
   // are no automatic TWs); extension TWs keep tw_n at TW_LAST so they are final too
   assign sample_pt = last_tick && ((state == ST_T2 && NO_WS) || (state == ST_TW && tw_n == TW_LAST));
   assign timeout   = ext == EXT_MAX;
   assign strobe    = state inside {ST_T2, ST_TW, ST_T3};
   assign rec_first = state == ST_RECOVER && cnt == '0;
   assign accept    = state == ST_IDLE && req;

   always_comb begin
      state_nxt = state;
      ready     = state == ST_IDLE;
      done      = rec_first;
      err       = rec_first && err_l;
      iorq_n    = !strobe;
      rd_n      = !(strobe && !wr_l);
      wr_n      = !(strobe && wr_l);
      // write data is held for one RECOVER clock after the strobes rise
      cd_oe     = wr_l && (state inside {ST_T1, ST_T2, ST_TW, ST_T3} || rec_first);
      case (state)
         ST_IDLE:    state_nxt = req ? ST_T1 : ST_IDLE;
         ST_T1:      state_nxt = last_tick ? ST_T2 : ST_T1;
         ST_T2,
         ST_TW:      if (sample_pt) state_nxt = wait_s ? ST_T3 : timeout ? ST_RECOVER : ST_TW;
                     else if (last_tick) state_nxt = ST_TW;
         ST_T3:      state_nxt = last_tick ? ST_RECOVER : ST_T3;
         ST_RECOVER: state_nxt = last_tick ? ST_IDLE : ST_RECOVER;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         addr    <= '0;
         cd_out  <= '0;
         rdata   <= '0;
         wr_l    <= 1'b0;
         err_l   <= 1'b0;
         tw_n    <= '0;
         ext     <= '0;
         wait_q1 <= 1'b1;
         wait_s  <= 1'b1;
      end else begin
         state   <= state_nxt;
         wait_q1 <= wait_n;
         wait_s  <= wait_q1;
         if (accept) begin
            wr_l   <= wr;
            addr   <= port_addr(PORT_BASE, port);
            cd_out <= wdata;
            err_l  <= 1'b0;
            tw_n   <= '0;
            ext    <= '0;
         end
         if (state == ST_TW && last_tick && tw_n != TW_LAST) tw_n <= tw_n + 2'd1;
         if (sample_pt && !wait_s && !timeout) ext <= ext + EW'(1);
         if (sample_pt && !wait_s && timeout) err_l <= 1'b1;
         if (state == ST_T3 && last_tick && !wr_l) rdata <= cd_in;
      end
   end
endmodule

// File: doc/z80_io_initiator.md
Name: z80_io_initiator

Overview:
- Bus-master counterpart to the VDP's host-side I/O slave decode.
- Generates Z80-style I/O read and write cycles (A[7:0], iorq_n, rd_n, wr_n, 8-bit data bus) towards VDP ports $98-$9B.
- Timing follows the Z80 T1/T2/TW/T3 sequence. Cycle lengths are in clk ticks.
- Used as an on-board self-test / boot pattern loader driving a V9958 target, and as the bus driver in system benches.

Parameters:
- T_STATE_CLKS, 8: clk ticks per Z80 T-state (27 MHz / ~3.4 MHz); must be >= 2.
- WAIT_STATES, 1: automatic TW states inserted per I/O cycle; range 0..3.
- GAP_CLKS, 4: idle clocks after T3 before the next request is accepted; must be >= 1. Lets the target's pin filters release.
- WAIT_TIMEOUT, 255: maximum extra TW states added by wait_n low before the cycle aborts.
- PORT_BASE, 8'h98: upper address bits; A = PORT_BASE | {6'b0, port}.

Ports:
- clk  in  1  single clock for all logic.
- reset_n  in  1  synchronous, active-low reset.
- req  in  1  request strobe; accepted when req & ready.
- wr  in  1  1 = I/O write, 0 = I/O read; sampled on accept.
- port  in  2  port select 0..3; sampled on accept.
- wdata  in  8  write data; sampled on accept.
- ready  out  1  high in IDLE; can accept a request.
- done  out  1  one-clock pulse when a cycle completes or aborts.
- err  out  1  valid with done; 1 = wait timeout abort.
- rdata  out  8  read data; held from done until the next accepted read.
- addr  out  8  bus address.
- iorq_n  out  1  I/O request strobe.
- rd_n  out  1  read strobe.
- wr_n  out  1  write strobe.
- cd_out  out  8  data driven during writes.
- cd_oe  out  1  data bus output enable; top-level tristate uses it.
- cd_in  in  8  bus data for reads.
- wait_n  in  1  target wait request; synchronised through 2 flops inside the block.

Behaviour:
- Reset (synchronous, reset_n low at a clk edge), including mid-cycle:
  - next edge: state IDLE; iorq_n = rd_n = wr_n = 1; cd_oe = 0; done = 0; err = 0; ready = 1; rdata = 0; addr = 0; cd_out = 0.
  - No partial strobe may persist.
- States: IDLE, T1, T2, TW, T3, RECOVER. A tick counter of width clog2(T_STATE_CLKS) times each T-state.
- IDLE:
  - ready = 1.
  - On req & ready at edge k: latch wr/port/wdata; addr = PORT_BASE | port; enter T1 at cycle k+1.
  - cd_oe = wr and cd_out = wdata from T1 onward.
- T1: lasts T_STATE_CLKS clocks; strobes inactive (address setup).
- T2:
  - iorq_n = 0 and (wr ? wr_n : rd_n) = 0 from the first T2 clock.
  - Lasts T_STATE_CLKS.
  - Then TW if WAIT_STATES > 0, else T3.
- TW:
  - Each TW lasts T_STATE_CLKS.
  - After WAIT_STATES TWs, the synchronised wait_n is sampled on the last clock of the final TW.
  - If it is low, another TW is appended (extension counter +1).
  - If the extension counter reaches WAIT_TIMEOUT with wait_n still low: deassert strobes, go to RECOVER, set err = 1, leave rdata unchanged.
- T3:
  - Lasts T_STATE_CLKS; strobes held low.
  - Read: rdata <= cd_in on the last T3 clock.
  - Strobes deassert at the first RECOVER clock.
- RECOVER:
  - done = 1 on the first clock only.
  - cd_oe stays 1 for that one clock (write hold), then 0. addr is held during it.
  - Lasts GAP_CLKS, then IDLE.
- Total latency, accept to done, with no extensions: (3 + WAIT_STATES) * T_STATE_CLKS + 1 clocks.
  - Default: done at k+33.
  - Strobes low k+9 .. k+32.
  - ready high again at k+33+GAP_CLKS (k+37).
- req while not ready is ignored; there is no queue, and the requester holds req until ready.
- wait_n is ignored outside the final TW sample point.
- WAIT_STATES = 0: wait_n is sampled on the last T2 clock instead.

Decomposition:
- Shared package z80_bus_pkg:
  - state enum (IDLE/T1/T2/TW/T3/RECOVER);
  - localparams VDP_PORT_BASE = 8'h98 and port indices (DATA = 0, CTRL = 1, PAL = 2, REGIND = 3).
- One sub-module, z80_tstate_timer: tick counter with a last_tick output, reloaded on each state change.
- The 2-flop wait_n synchroniser stays inline.

Test Plan:
- Write, defaults: req with wr=1, port=1, wdata=8'h8F at k → addr=8'h99 from k+1; cd_oe=1 k+1..k+33; iorq_n=wr_n=0 exactly k+9..k+32; rd_n=1 throughout; done=1 only at k+33, err=0; ready at k+37.
- Read: cd_in=8'h5A, wr=0, port=0 → addr=8'h98, rd_n low k+9..k+32, cd_oe=0 throughout, rdata=8'h5A at done (k+33), held until the next read.
- Wait extension: wait_n low for 20 clocks spanning the TW sample point → exactly one extra TW, done at k+41, data correct.
- Timeout: WAIT_TIMEOUT=2, wait_n held low → strobes released after 2 extra TWs, done with err=1, rdata unchanged.
- Reset mid-cycle: reset_n low during T3 of a write → next edge all strobes 1, cd_oe=0, ready=1, no done pulse. A subsequent request completes normally.
- Back-to-back: req held high over 3 writes → accepts only when ready; 3 done pulses spaced 37 clocks apart; req during RECOVER ignored.
